// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: small byte FIFO plus launch controller sitting ahead of the UART TX FSM.
// Each launch pops one byte onto P_DATA with a one-cycle Data_Valid; P_DATA then holds for the whole frame.
module uart_tx_feeder #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4,
   parameter int LAUNCH_TMO = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  WR_EN,
   input  logic [DATA_WIDTH-1:0] WR_DATA,
   input  logic                  busy,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  Data_Valid,
   output logic                  FIFO_FULL,
   output logic                  FIFO_EMPTY,
   output logic                  OVERFLOW,
   output logic                  LAUNCH_ERR,
   output logic [1:0]            dbg_state_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = (LAUNCH_TMO > 1) ? $clog2(LAUNCH_TMO) : 1;
   localparam logic [CW-1:0] TMO_LAST = CW'(LAUNCH_TMO - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         wptr_q, wptr_d;
   logic [PW-1:0]         rptr_q, rptr_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
   logic                  dv_q, dv_d;
   logic                  ovf_q, ovf_d;
   logic                  err_q, err_d;
   logic [CW-1:0]         cnt_q, cnt_d;

   logic full;
   logic empty;
   logic push;
   logic launch;
   logic tmo_hit;

   // Extra pointer MSB distinguishes full from empty when the index bits match.
   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign push    = WR_EN && !full;
   assign launch  = (state_q == S_IDLE) && !empty && !busy;
   assign tmo_hit = (state_q == S_WAIT_BUSY) && !busy && (cnt_q == TMO_LAST);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      ovf_d  = ovf_q;
      if (push) begin
         wptr_d = wptr_q + PW'(1);
      end
      if (WR_EN && full) begin
         ovf_d = 1'b1;
      end
      if (launch) begin
         rptr_d = rptr_q + PW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         mem_q[wptr_q[AW-1:0]] <= WR_DATA;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (launch) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (busy) begin
               state_d = S_WAIT_DONE;
            end else if (tmo_hit) begin
               state_d = S_IDLE;
            end
         end
         S_WAIT_DONE: begin
            if (!busy) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // A timed-out byte is dropped; only the sticky error records it.
   always_comb begin
      dv_d    = launch;
      pdata_d = pdata_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (launch) begin
         pdata_d = mem_q[rptr_q[AW-1:0]];
      end
      case (state_q)
         S_ISSUE: begin
            cnt_d = '0;
         end
         S_WAIT_BUSY: begin
            if (!busy && !tmo_hit) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
         end
      endcase
      if (tmo_hit) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         pdata_q <= '0;
         dv_q    <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         pdata_q <= pdata_d;
         dv_q    <= dv_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign P_DATA      = pdata_q;
   assign Data_Valid  = dv_q;
   assign FIFO_FULL   = full;
   assign FIFO_EMPTY  = empty;
   assign OVERFLOW    = ovf_q;
   assign LAUNCH_ERR  = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a behavioural TX FSM drives busy, a scoreboard queue holds the bytes
// expected on P_DATA in launch order, and a negedge monitor checks every Data_Valid pulse.
module tb_uart_tx_feeder;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int TMO   = 3;
   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_DONE = 2'd3;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          WR_EN = 1'b0;
   logic [DW-1:0] WR_DATA = '0;
   logic          tx_busy = 1'b0;
   logic          busy_force = 1'b0;
   logic          busy;
   logic [DW-1:0] P_DATA;
   logic          Data_Valid;
   logic          FIFO_FULL;
   logic          FIFO_EMPTY;
   logic          OVERFLOW;
   logic          LAUNCH_ERR;
   logic [1:0]    dbg_state;

   assign busy = tx_busy | busy_force;

   uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LAUNCH_TMO(TMO)) dut (
      .CLK(CLK), .RST(RST), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .busy(busy),
      .P_DATA(P_DATA), .Data_Valid(Data_Valid), .FIFO_FULL(FIFO_FULL),
      .FIFO_EMPTY(FIFO_EMPTY), .OVERFLOW(OVERFLOW), .LAUNCH_ERR(LAUNCH_ERR),
      .dbg_state_o(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial forever #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int            total = 0;
   int            bad = 0;
   logic [DW-1:0] exp_q[$];
   logic          exp_ovf = 1'b0;
   logic          exp_err = 1'b0;
   logic [DW-1:0] last_pdata = '0;
   logic          prev_dv = 1'b0;
   int            pulses = 0;

   // behavioural TX FSM
   logic tx_arm = 1'b0;
   logic tx_respond = 1'b1;
   int   tx_cnt = 0;
   int   frame_len = 0;
   logic gap_chk = 1'b0;
   logic fall_pending = 1'b0;
   int   last_fall = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- monitor + TX model ----------------
   always @(negedge CLK) begin
      if (RST) begin
         prev_dv = 1'b0;
         tx_arm  = 1'b0;
         tx_busy = 1'b0;
         tx_cnt  = 0;
      end else begin
         if (Data_Valid) begin
            pulses++;
            chk("dv_single_cycle", {31'd0, prev_dv}, 32'd0);
            chk("dv_while_busy", {31'd0, busy}, 32'd0);
            chk("pulse_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) chk("p_data", {24'd0, P_DATA}, {24'd0, exp_q.pop_front()});
            if (gap_chk && fall_pending) chk("relaunch_gap", cyc, last_fall + 2);
            fall_pending = 1'b0;
            last_pdata = P_DATA;
         end else begin
            chk("p_data_hold", {24'd0, P_DATA}, {24'd0, last_pdata});
         end
         prev_dv = Data_Valid;

         if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
               tx_busy = 1'b0;
               last_fall = cyc;
               fall_pending = 1'b1;
            end
         end else if (tx_arm) begin
            tx_busy = 1'b1;
            tx_cnt  = (frame_len != 0) ? frame_len : int'($urandom_range(2, 8));
            tx_arm  = 1'b0;
         end
         if (Data_Valid && tx_respond) tx_arm = 1'b1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   // Model: a write is accepted while fewer than DEPTH bytes are outstanding, else it sets overflow.
   task automatic wr(input logic [DW-1:0] d);
      WR_EN = 1'b1;
      WR_DATA = d;
      if (exp_q.size() < DEPTH) exp_q.push_back(d);
      else exp_ovf = 1'b1;
      tick();
      WR_EN = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (n < 400 && !(exp_q.size() == 0 && !busy && !tx_arm && !Data_Valid && dbg_state == ST_IDLE)) begin
         tick();
         n++;
      end
      chk({name, "_drain"}, {31'd0, n < 400}, 32'd1);
   endtask

   task automatic check_flags(input string name);
      chk({name, "_overflow"}, {31'd0, OVERFLOW}, {31'd0, exp_ovf});
      chk({name, "_launch_err"}, {31'd0, LAUNCH_ERR}, {31'd0, exp_err});
   endtask

   task automatic check_reset_values(input string name);
      chk({name, "_p_data"}, {24'd0, P_DATA}, 32'd0);
      chk({name, "_dv"}, {31'd0, Data_Valid}, 32'd0);
      chk({name, "_empty"}, {31'd0, FIFO_EMPTY}, 32'd1);
      chk({name, "_full"}, {31'd0, FIFO_FULL}, 32'd0);
      chk({name, "_state"}, {30'd0, dbg_state}, {30'd0, ST_IDLE});
      check_flags(name);
   endtask

   task automatic random_stream(input string name, input int count, input int limit, input logic seq);
      int sent = 0;
      int guard = 0;
      int p0 = pulses;
      while (sent < count && guard < 3000) begin
         if (exp_q.size() < limit && $urandom_range(0, 2) != 0) begin
            wr(seq ? DW'(sent) : DW'($urandom_range(0, 255)));
            sent++;
         end else begin
            tick();
         end
         guard++;
      end
      wait_idle(name);
      chk({name, "_pulse_count"}, pulses - p0, count);
   endtask

   // ---------------- test sequence ----------------
   initial begin : main
      int p0;
      int n;
      int d;

      repeat (3) tick();
      check_reset_values("reset_held");
      RST = 1'b0;
      tick();
      check_reset_values("reset_released");

      // single byte, 11-cycle frame
      frame_len = 11;
      wr(8'hA5);
      chk("single_c0_dv", {31'd0, Data_Valid}, 32'd0);
      chk("single_c0_empty", {31'd0, FIFO_EMPTY}, 32'd0);
      tick();
      chk("single_c1_dv", {31'd0, Data_Valid}, 32'd1);
      chk("single_c1_data", {24'd0, P_DATA}, 32'hA5);
      tick();
      chk("single_c2_dv", {31'd0, Data_Valid}, 32'd0);
      chk("single_c2_empty", {31'd0, FIFO_EMPTY}, 32'd1);
      tick();
      chk("single_wait_done", {30'd0, dbg_state}, {30'd0, ST_WAIT_DONE});
      wait_idle("single");
      chk("single_p_data_kept", {24'd0, P_DATA}, 32'hA5);

      // burst of four queued behind a busy frame
      frame_len = 0;
      fall_pending = 1'b0;
      gap_chk = 1'b1;
      busy_force = 1'b1;
      p0 = pulses;
      tick();
      wr(8'h11);
      wr(8'h22);
      wr(8'h33);
      wr(8'h44);
      chk("burst_full", {31'd0, FIFO_FULL}, 32'd1);
      chk("burst_not_empty", {31'd0, FIFO_EMPTY}, 32'd0);
      busy_force = 1'b0;
      wait_idle("burst");
      gap_chk = 1'b0;
      chk("burst_pulse_count", pulses - p0, 4);
      check_flags("burst");

      // wrap-around with occupancy kept at 3 or below, then a free-running random stream
      random_stream("wrap", 10, 3, 1'b1);
      random_stream("random", 40, DEPTH, 1'b0);
      check_flags("random");

      // overflow: five writes while the transmitter is busy
      busy_force = 1'b1;
      p0 = pulses;
      tick();
      for (int i = 0; i < 5; i++) wr(DW'($urandom_range(0, 255)));
      chk("ovf_full", {31'd0, FIFO_FULL}, 32'd1);
      check_flags("ovf_set");
      busy_force = 1'b0;
      wait_idle("ovf");
      chk("ovf_pulse_count", pulses - p0, 4);
      check_flags("ovf_sticky");

      // launch timeout: transmitter never answers
      tx_respond = 1'b0;
      wr(8'h5A);
      n = 0;
      while (n < 10 && !Data_Valid) begin
         tick();
         n++;
      end
      chk("tmo_pulse_seen", {31'd0, Data_Valid}, 32'd1);
      d = cyc;
      repeat (3) tick();
      chk("tmo_err_not_yet", {31'd0, LAUNCH_ERR}, 32'd0);
      chk("tmo_cyc_offset", cyc, d + 3);
      tick();
      exp_err = 1'b1;
      chk("tmo_err_set", {31'd0, LAUNCH_ERR}, 32'd1);
      chk("tmo_state_idle", {30'd0, dbg_state}, {30'd0, ST_IDLE});
      tx_respond = 1'b1;
      wr(DW'($urandom_range(0, 255)));
      wait_idle("tmo_recover");
      check_flags("tmo_sticky");

      // reset mid-frame with two bytes queued
      frame_len = 20;
      wr(8'h77);
      n = 0;
      while (n < 20 && dbg_state != ST_WAIT_DONE) begin
         tick();
         n++;
      end
      chk("rst_reached_wait_done", {30'd0, dbg_state}, {30'd0, ST_WAIT_DONE});
      wr(8'h88);
      wr(8'h99);
      chk("rst_queue_nonempty", {31'd0, FIFO_EMPTY}, 32'd0);
      tick();
      exp_q.delete();
      last_pdata = '0;
      exp_ovf = 1'b0;
      exp_err = 1'b0;
      RST = 1'b1;
      #1;
      check_reset_values("rst_async");
      tick();
      RST = 1'b0;
      p0 = pulses;
      repeat (30) tick();
      chk("rst_no_pulses", pulses - p0, 0);
      check_reset_values("rst_after");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
